// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that serialises requester writes into one loadable register,
// acknowledges each capture and flags readback mismatches.
module reg_load_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0]       reg_q,
    input  logic                   err_clr,
    output logic                   lode,
    output logic [WIDTH-1:0]       data_in,
    output logic [N_REQ-1:0]       ack,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   err,
    output logic [1:0]             state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam int SEL_W = $clog2(N_REQ);

    // Handshake: req[i] is a level held with req_data[i] until ack[i] pulses;
    // req is only sampled in IDLE, ack[i] is a one-cycle pulse after the load.

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] data_a [N_REQ];
    logic [SEL_W-1:0] hi_idx, lo_idx, pick_idx;
    logic             hi_found;
    logic [WIDTH-1:0] pick_data;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
        assign data_a[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // Lowest set request at or above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j[SEL_W-1:0]]) begin
                lo_idx = j[SEL_W-1:0];
                if (j >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = j[SEL_W-1:0];
                end
            end
        end
        pick_idx  = hi_found ? hi_idx : lo_idx;
        pick_data = data_a[pick_idx];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        err_d   = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    hold_d  = pick_data;
                    grant_d = IDW'(pick_idx);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // A mismatch set overrides a same-cycle clear.
                if (reg_q != hold_q) begin
                    err_d = 1'b1;
                end
                ptr_d   = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        ack = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (state_q == ST_ACK && grant_q == IDW'(j)) begin
                ack[j[SEL_W-1:0]] = 1'b1;
            end
        end
    end

    // hold only changes on a grant, so data_in stays at the last loaded value.
    assign lode      = (state_q == ST_LOAD);
    assign data_in   = hold_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model and a register-load scoreboard.
module tb_reg_load_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IDW = 2;

  logic CLK = 1'b0;
  logic RST;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [W-1:0] reg_q;
  logic err_clr;
  logic lode;
  logic [W-1:0] data_in;
  logic [N-1:0] ack;
  logic [IDW-1:0] grant_id;
  logic busy;
  logic err;
  logic [1:0] state_dbg;

  logic corrupt = 1'b0;
  logic [W-1:0] reg_store = '0;
  assign reg_q = corrupt ? '0 : reg_store;

  reg_load_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .reg_q(reg_q),
    .err_clr(err_clr), .lode(lode), .data_in(data_in), .ack(ack),
    .grant_id(grant_id), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cnt counts remaining busy cycles after a grant: 2 = loading, 1 = acknowledging.
  int m_cnt = 0;
  int m_ptr = 0;
  int m_g = 0;
  logic [W-1:0] m_hold = '0;
  logic m_err = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_cnt = 0; m_ptr = 0; m_g = 0; m_hold = '0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      if (err_clr) m_err = 1'b0;
      if (m_cnt == 1) begin
        if (reg_q !== m_hold) m_err = 1'b1;
        m_ptr = (m_g + 1) % N;
        m_cnt = 0;
      end else if (m_cnt == 2) begin
        m_cnt = 1;
      end else if (req != 0) begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          if (!found && req[c]) begin
            found = 1'b1;
            m_g = c;
          end
        end
        m_hold = req_data[m_g*W +: W];
        m_cnt = 2;
        exp_q.push_back(m_hold);
      end
    end
  end

  // Register model plus load scoreboard.
  always @(posedge CLK) begin
    if (lode) begin
      reg_store <= data_in;
      chk("sb_pending", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) chk("sb_load_data", 32'(data_in), 32'(exp_q.pop_front()));
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    chk("lode", 32'(lode), 32'(m_cnt == 2));
    chk("data_in", 32'(data_in), 32'(m_hold));
    chk("ack", 32'(ack), (m_cnt == 1) ? (32'd1 << m_g) : 32'd0);
    chk("grant_id", 32'(grant_id), 32'(m_g));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("err", 32'(err), 32'(m_err));
  end

  // Observed ack history.
  int ack_id_log[$];
  logic [W-1:0] ack_dat_log[$];
  int ack_cyc_log[$];
  always @(negedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ack_id_log.push_back(i);
        ack_dat_log.push_back(data_in);
        ack_cyc_log.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    step();
    RST = 1'b1;
  endtask

  task automatic clear_logs();
    ack_id_log.delete();
    ack_dat_log.delete();
    ack_cyc_log.delete();
  endtask

  task automatic wait_acks(int n, int budget);
    int start;
    int k;
    start = ack_id_log.size();
    k = 0;
    while (ack_id_log.size() < start + n && k < budget) begin
      step();
      k++;
    end
    chk("ack_timeout", 32'(ack_id_log.size() >= start + n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int exp_ids[5] = '{0, 1, 2, 3, 0};
  logic [W-1:0] exp_dat[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  initial begin
    int n_before;
    RST = 1'b1; req = '0; req_data = '0; err_clr = 1'b0;
    #1 RST = 1'b0;
    #1;
    chk("rst_lode", 32'(lode), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step(); step();
    RST = 1'b1;

    // Single request.
    req_data[2*W +: W] = 8'hA5;
    req = 4'b0100;
    step();
    chk("t1_lode", 32'(lode), 32'd1);
    chk("t1_data_in", 32'(data_in), 32'hA5);
    chk("t1_grant_id", 32'(grant_id), 32'd2);
    step();
    chk("t1_ack", 32'(ack), 32'b0100);
    chk("t1_lode_low", 32'(lode), 32'd0);
    req = '0;
    step();
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_reg_q", 32'(reg_q), 32'hA5);
    chk("t1_data_hold", 32'(data_in), 32'hA5);

    // Full contention from reset.
    pulse_reset();
    clear_logs();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    wait_acks(5, 40);
    req = '0;
    chk("t2_ack_count", 32'(ack_id_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < ack_id_log.size(); i++) begin
      chk("t2_ack_order", 32'(ack_id_log[i]), 32'(exp_ids[i]));
      chk("t2_ack_data", 32'(ack_dat_log[i]), 32'(exp_dat[i]));
      if (i > 0) chk("t2_ack_spacing", 32'(ack_cyc_log[i] - ack_cyc_log[i-1]), 32'd3);
    end
    step();

    // Fairness after pointer wraps.
    req_data[3*W +: W] = 8'h3D;
    req = 4'b1000;
    wait_acks(1, 10);
    req = '0;
    step();
    clear_logs();
    req_data[0 +: W] = 8'h0D;
    req = 4'b1001;
    wait_acks(2, 20);
    req = '0;
    chk("t3_first", (ack_id_log.size() > 0) ? 32'(ack_id_log[0]) : 32'hFFFF, 32'd0);
    chk("t3_second", (ack_id_log.size() > 1) ? 32'(ack_id_log[1]) : 32'hFFFF, 32'd3);
    step();

    // Readback error, stickiness, clear, set-wins.
    corrupt = 1'b1;
    req_data[0 +: W] = 8'hFF;
    req = 4'b0001;
    wait_acks(1, 10);
    req = '0;
    chk("t4_err_set", 32'(err), 32'd1);
    corrupt = 1'b0;
    req_data[1*W +: W] = 8'h3C;
    req = 4'b0010;
    wait_acks(1, 10);
    req = '0;
    step();
    chk("t4_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_clr", 32'(err), 32'd0);
    corrupt = 1'b1;
    err_clr = 1'b1;
    req_data[2*W +: W] = 8'h99;
    req = 4'b0100;
    wait_acks(1, 10);
    req = '0;
    chk("t4_set_wins", 32'(err), 32'd1);
    corrupt = 1'b0;
    step();
    chk("t4_err_clr2", 32'(err), 32'd0);
    err_clr = 1'b0;

    // Reset during LOAD.
    req_data[1*W +: W] = 8'h77;
    req = 4'b0010;
    step();
    chk("t5_lode", 32'(lode), 32'd1);
    #1 RST = 1'b0;
    #1;
    chk("t5_lode_rst", 32'(lode), 32'd0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_ack_rst", 32'(ack), 32'd0);
    n_before = ack_id_log.size();
    step(); step();
    chk("t5_no_ack", 32'(ack_id_log.size()), 32'(n_before));
    RST = 1'b1;
    step();
    chk("t5_regrant_id", 32'(grant_id), 32'd1);
    chk("t5_regrant_lode", 32'(lode), 32'd1);
    chk("t5_regrant_data", 32'(data_in), 32'h77);
    wait_acks(1, 10);
    req = '0;
    step();

    // Data change during LOAD is ignored.
    req_data[0 +: W] = 8'h5A;
    req = 4'b0001;
    step();
    chk("t6_lode", 32'(lode), 32'd1);
    req_data[0 +: W] = 8'hC3;
    step();
    chk("t6_ack", 32'(ack), 32'b0001);
    chk("t6_reg_q", 32'(reg_q), 32'h5A);
    req = '0;
    step();
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_data_in", 32'(data_in), 32'h5A);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom_range(0, 15));
      req_data = $urandom;
      err_clr = ($urandom_range(0, 7) == 0);
      corrupt = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 63) == 0) begin
        #1 RST = 1'b0;
        #1 RST = 1'b1;
      end
      step();
    end
    req = '0;
    corrupt = 1'b0;
    err_clr = 1'b0;
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
